fp32_to_int: RTL and testbench
==============================

// Module: fp32_to_int
// PURPOSE
//  Multi-cycle converter from IEEE-754 binary32 to a signed or unsigned INT_W-bit integer.
//  It decodes the float word that the FP adder path produces. It is the inverse end of the
//  float encoding: unpack, align by an iterative shifter, round to nearest-even, then saturate.
//  Valid/ready handshake on both sides; it sits between the FP datapath and integer consumers.
// PARAMETERS
//  INT_W   32  result width; legal range 25..64 (rounding can never overflow the integer)
//  STEP     4  max bits shifted per SHIFT cycle; legal range 1..8
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      in_data/in_signed valid
//  in_ready   out  1      converter can accept (high only in IDLE, low while rst)
//  in_data    in   32     binary32 operand {sign, exp[7:0], man[22:0]}
//  in_signed  in   1      1: two's-complement result, 0: unsigned result
//  out_valid  out  1      out_data/out_flags valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  INT_W  converted integer
//  out_flags  out  3      {invalid, overflow, inexact}
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, out_data=0, out_flags=0. Reset mid-transaction discards it.
//  Accept on in_valid&in_ready. Latch sign, exp, sig={|exp, man}, and e=exp-127.
//  FSM IDLE->SHIFT->ROUND->OUT->IDLE. Specials and zero go IDLE->OUT directly.
//  Special classes, evaluated at accept time:
//   - NaN (exp=255, man!=0): invalid=1; data = signed ? 2^(INT_W-1)-1 : all-ones.
//   - Inf, or e>=INT_W (unsigned), or e>=INT_W-1 (signed): overflow=1.
//     Data saturates to max (+) or min (- signed). Unsigned negative saturates to 0 with invalid=1.
//     Exception: signed, sign=1, e=INT_W-1, man=0 is exact min, no flags.
//   - exp=0 and man=0: data 0, no flags.
//  Alignment:
//   - e>=23: left shift by e-23, no fraction bits.
//   - e<23: right shift by min(23-e, 26); keep round bit R; OR every bit shifted out below R into sticky S.
//  SHIFT: moves min(STEP, remaining) bits per cycle; k=ceil(shamt/STEP) cycles; shamt=0 skips SHIFT.
//  ROUND: L=LSB of integer part. Increment iff R&(L|S). inexact=R|S.
//   - Signed: negative sign negates magnitude.
//   - Unsigned: negative with rounded magnitude!=0 gives data 0 and invalid=1 (inexact unchanged);
//     rounded magnitude 0 gives data 0, inexact only.
//  Latency, accept to out_valid: normal k+2 cycles; special 1 cycle.
//  OUT: out_valid held, data/flags stable until out_ready; the handshake cycle returns to IDLE.
//   in_ready=0 in OUT (no overlap). Throughput: one conversion per latency+1 cycles minimum.
//  Simultaneous in_valid during SHIFT/ROUND/OUT is ignored (in_ready=0); source must hold.
// STRUCTURE
//  Shared package fp_pkg: EXP_W=8, MAN_W=23, BIAS=127, FP32 field typedef, conv state enum,
//   flag bit indices (FLG_INV=2, FLG_OVF=1, FLG_NX=0).
//  Sub-module fp32_classify (combinational): fields -> {is_nan, is_inf, is_zero, e, sig}.
//  Shifter, sticky, RNE incrementer and FSM live in fp32_to_int.
// TESTING
//  1. 0x40490FDB (3.14159) signed -> 0x00000003, flags 001; shamt 22, k=6, out_valid 8 cycles after accept.
//  2. 0x3FC00000 (1.5) -> 2; 0x40200000 (2.5) -> 2; 0xC0200000 (-2.5) signed -> 0xFFFFFFFE; all flags 001.
//  3. 0x4F000000 (2^31): signed -> 0x7FFFFFFF flags 010; unsigned -> 0x80000000 flags 000;
//     0xCF000000 signed -> 0x80000000 flags 000.
//  4. 0x7FC00000 (NaN) signed -> 0x7FFFFFFF flags 100; 0xBF800000 (-1.0) unsigned -> 0 flags 100;
//     0xBE800000 (-0.25) unsigned -> 0 flags 001.
//  5. 0x00000001 (denormal) -> 0 flags 001; 0x80000000 (-0) -> 0 flags 000, 1-cycle latency.
//  6. out_ready low 5 cycles in OUT: out_data/flags stable, in_ready=0. rst in mid-SHIFT:
//     next cycle out_valid=0, in_ready=1 after rst drops, and the next conversion is correct.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared binary32 field layout, converter state encoding and
//                result flag positions for the float-to-integer path.
//  Revision    : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Unbiased exponent width: covers -127..128 as a signed value.
    localparam int E_W   = 10;

    // Positions inside the {invalid, overflow, inexact} flag vector.
    localparam int FLG_INV = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_NX  = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_OUT   = 2'd3
    } conv_state_t;

endpackage
`default_nettype wire

// File: rtl/fp32_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_classify
//  Description : Combinational unpack of a binary32 word into class bits,
//                unbiased exponent and significand with hidden bit.
//  Revision    : 1.0  initial release
// ============================================================================
module fp32_classify
    import fp_pkg::*;
(
    input  fp32_t                i_word,
    output logic                 o_is_nan,
    output logic                 o_is_inf,
    output logic                 o_is_zero,
    output logic signed [E_W-1:0] o_exp_unb,
    output logic [MAN_W:0]       o_sig
);

    logic w_exp_max;
    logic w_exp_min;
    logic w_man_zero;

    assign w_exp_max  = (i_word.exp == {EXP_W{1'b1}});
    assign w_exp_min  = (i_word.exp == {EXP_W{1'b0}});
    assign w_man_zero = (i_word.man == {MAN_W{1'b0}});

    assign o_is_nan  = w_exp_max && !w_man_zero;
    assign o_is_inf  = w_exp_max &&  w_man_zero;
    assign o_is_zero = w_exp_min &&  w_man_zero;

    // Denormals keep e = -127; the right-shift clamp makes the off-by-one moot.
    assign o_exp_unb = E_W'({2'b00, i_word.exp}) - E_W'(BIAS);
    assign o_sig     = {!w_exp_min, i_word.man};

endmodule
`default_nettype wire

// File: rtl/fp32_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : fp32_to_int
//  Description : Multi-cycle binary32 to signed/unsigned integer converter.
//                Unpack, iterative align, round-to-nearest-even, saturate.
//  Revision    : 1.0  initial release
// ============================================================================
module fp32_to_int
    import fp_pkg::*;
#(
    parameter int INT_W = 32,
    parameter int STEP  = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_data,
    output logic [2:0]       out_flags
);

    // Working vector is {integer magnitude, round bit}; sticky kept apart.
    localparam int XW  = INT_W + 1;
    localparam int SHW = 7;

    localparam logic [SHW-1:0]        c_step    = SHW'(STEP);
    localparam logic signed [E_W-1:0] c_man_s   = E_W'(MAN_W);
    localparam logic signed [E_W-1:0] c_rmax_s  = E_W'(MAN_W + 3);
    localparam logic signed [E_W-1:0] c_ovf_u_s = E_W'(INT_W);
    localparam logic signed [E_W-1:0] c_ovf_s_s = E_W'(INT_W - 1);
    localparam logic [INT_W-1:0]      c_max_s   = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0]      c_min_s   = {1'b1, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0]      c_ones    = {INT_W{1'b1}};

    conv_state_t      state_q,     state_d;
    logic             sign_q,      sign_d;
    logic             signed_q,    signed_d;
    logic             left_q,      left_d;
    logic [SHW-1:0]   shamt_q,     shamt_d;
    logic [XW-1:0]    x_q,         x_d;
    logic             sticky_q,    sticky_d;
    logic [INT_W-1:0] out_data_q,  out_data_d;
    logic [2:0]       out_flags_q, out_flags_d;

    fp32_t                w_fields;
    logic                 w_is_nan;
    logic                 w_is_inf;
    logic                 w_is_zero;
    logic signed [E_W-1:0] w_e;
    logic [MAN_W:0]       w_sig;

    assign w_fields = fp32_t'(in_data);

    fp32_classify u_classify (
        .i_word    (w_fields),
        .o_is_nan  (w_is_nan),
        .o_is_inf  (w_is_inf),
        .o_is_zero (w_is_zero),
        .o_exp_unb (w_e),
        .o_sig     (w_sig)
    );

    // Accept-time classification of the incoming operand.
    logic                  w_accept;
    logic                  w_ovf_range;
    logic                  w_exact_min;
    logic                  w_go_left;
    logic signed [E_W-1:0] w_ldist;
    logic signed [E_W-1:0] w_rdist;
    logic [SHW-1:0]        w_shamt_init;

    assign w_accept    = in_valid && in_ready;
    assign w_ovf_range = in_signed ? (w_e >= c_ovf_s_s) : (w_e >= c_ovf_u_s);
    assign w_exact_min = in_signed && w_fields.sign && (w_e == c_ovf_s_s)
                         && (w_fields.man == {MAN_W{1'b0}});
    assign w_go_left   = (w_e >= c_man_s);
    assign w_ldist     = w_e - c_man_s;
    assign w_rdist     = c_man_s - w_e;
    assign w_shamt_init = w_go_left ? w_ldist[SHW-1:0]
                        : ((w_rdist > c_rmax_s) ? c_rmax_s[SHW-1:0] : w_rdist[SHW-1:0]);

    // One alignment step: at most STEP bits, never past the remaining count.
    logic [SHW-1:0] w_step_n;
    logic [XW-1:0]  w_drop_mask;
    logic           w_step_last;

    assign w_step_n    = (shamt_q > c_step) ? c_step : shamt_q;
    assign w_drop_mask = (XW'(1) << w_step_n) - XW'(1);
    assign w_step_last = (shamt_q == w_step_n);

    // Round-to-nearest-even on the aligned magnitude.
    logic [INT_W-1:0] w_mag;
    logic             w_r;
    logic             w_l;
    logic             w_inc;
    logic [INT_W-1:0] w_rounded;
    logic             w_nx;

    assign w_mag     = x_q[XW-1:1];
    assign w_r       = x_q[0];
    assign w_l       = x_q[1];
    assign w_inc     = w_r && (w_l || sticky_q);
    assign w_rounded = w_mag + {{(INT_W-1){1'b0}}, w_inc};
    assign w_nx      = w_r || sticky_q;

    // Next-state, datapath and result computation.
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        signed_d    = signed_q;
        left_d      = left_q;
        shamt_d     = shamt_q;
        x_d         = x_q;
        sticky_d    = sticky_q;
        out_data_d  = out_data_q;
        out_flags_d = out_flags_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    out_flags_d = 3'b000;
                    if (w_is_nan) begin
                        out_data_d           = in_signed ? c_max_s : c_ones;
                        out_flags_d[FLG_INV] = 1'b1;
                        state_d              = ST_OUT;
                    end else if (w_is_zero) begin
                        out_data_d = '0;
                        state_d    = ST_OUT;
                    end else if (w_exact_min) begin
                        out_data_d = c_min_s;
                        state_d    = ST_OUT;
                    end else if (w_is_inf || w_ovf_range) begin
                        if (!w_fields.sign) begin
                            out_data_d           = in_signed ? c_max_s : c_ones;
                            out_flags_d[FLG_OVF] = 1'b1;
                        end else if (in_signed) begin
                            out_data_d           = c_min_s;
                            out_flags_d[FLG_OVF] = 1'b1;
                        end else begin
                            out_data_d           = '0;
                            out_flags_d[FLG_INV] = 1'b1;
                        end
                        state_d = ST_OUT;
                    end else begin
                        sign_d   = w_fields.sign;
                        signed_d = in_signed;
                        left_d   = w_go_left;
                        shamt_d  = w_shamt_init;
                        x_d      = XW'({w_sig, 1'b0});
                        sticky_d = 1'b0;
                        state_d  = (w_shamt_init == '0) ? ST_ROUND : ST_SHIFT;
                    end
                end
            end

            ST_SHIFT: begin
                if (left_q) begin
                    x_d = x_q << w_step_n;
                end else begin
                    x_d      = x_q >> w_step_n;
                    sticky_d = sticky_q || ((x_q & w_drop_mask) != '0);
                end
                shamt_d = shamt_q - w_step_n;
                if (w_step_last) begin
                    state_d = ST_ROUND;
                end
            end

            ST_ROUND: begin
                out_flags_d         = 3'b000;
                out_flags_d[FLG_NX] = w_nx;
                if (signed_q) begin
                    out_data_d = sign_q ? (~w_rounded + {{(INT_W-1){1'b0}}, 1'b1})
                                        : w_rounded;
                end else if (sign_q) begin
                    out_data_d           = '0;
                    out_flags_d[FLG_INV] = (w_rounded != '0);
                end else begin
                    out_data_d = w_rounded;
                end
                state_d = ST_OUT;
            end

            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            signed_q    <= 1'b0;
            left_q      <= 1'b0;
            shamt_q     <= '0;
            x_q         <= '0;
            sticky_q    <= 1'b0;
            out_data_q  <= '0;
            out_flags_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            signed_q    <= signed_d;
            left_q      <= left_d;
            shamt_q     <= shamt_d;
            x_q         <= x_d;
            sticky_q    <= sticky_d;
            out_data_q  <= out_data_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_flags = out_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_to_int.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp32_to_int
//  Description : Directed self-checking bench for the binary32 to integer
//                converter: rounding, saturation, specials, latency, stall
//                and mid-conversion reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fp32_to_int;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    int checks;
    int errors;

    fp32_to_int #(.INT_W(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one operand, measure accept-to-out_valid latency, check result,
    // optionally stall the consumer for some cycles, then complete handshake.
    task automatic run(input string tag, input logic [31:0] d, input logic s,
                       input logic [31:0] ed, input logic [2:0] ef,
                       input int elat, input int hold);
        int lat;
        @(negedge clk);
        in_data   = d;
        in_signed = s;
        in_valid  = 1'b1;
        check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, elat);
        check({tag, " data"}, out_data, ed);
        check({tag, " flags"}, out_flags, ef);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, out_valid, 1);
            check({tag, " hold data"}, out_data, ed);
            check({tag, " hold flags"}, out_flags, ef);
            check({tag, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " released"}, out_valid, 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_flags", out_flags, 0);
        check("reset in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);

        // Rounding and alignment through the iterative shifter.
        run("pi",        32'h40490FDB, 1'b1, 32'h00000003, 3'b001, 8, 0);
        run("1.5",       32'h3FC00000, 1'b1, 32'h00000002, 3'b001, 8, 0);
        run("2.5",       32'h40200000, 1'b0, 32'h00000002, 3'b001, 8, 0);
        run("-2.5",      32'hC0200000, 1'b1, 32'hFFFFFFFE, 3'b001, 8, 0);
        run("0.5u",      32'h3F000000, 1'b0, 32'h00000000, 3'b001, 8, 0);
        run("2^23",      32'h4B000000, 1'b1, 32'h00800000, 3'b000, 2, 0);

        // Range boundaries.
        run("2^31 s",    32'h4F000000, 1'b1, 32'h7FFFFFFF, 3'b010, 1, 0);
        run("2^31 u",    32'h4F000000, 1'b0, 32'h80000000, 3'b000, 4, 0);
        run("-2^31 s",   32'hCF000000, 1'b1, 32'h80000000, 3'b000, 1, 0);
        run("maxu",      32'h4F7FFFFF, 1'b0, 32'hFFFFFF00, 3'b000, 4, 0);
        run("2^32 u",    32'h4F800000, 1'b0, 32'hFFFFFFFF, 3'b010, 1, 0);

        // Specials and negative-unsigned handling.
        run("nan s",     32'h7FC00000, 1'b1, 32'h7FFFFFFF, 3'b100, 1, 0);
        run("+inf u",    32'h7F800000, 1'b0, 32'hFFFFFFFF, 3'b010, 1, 0);
        run("-inf s",    32'hFF800000, 1'b1, 32'h80000000, 3'b010, 1, 0);
        run("-1.0 u",    32'hBF800000, 1'b0, 32'h00000000, 3'b100, 8, 0);
        run("-0.25 u",   32'hBE800000, 1'b0, 32'h00000000, 3'b001, 9, 0);
        run("denorm",    32'h00000001, 1'b1, 32'h00000000, 3'b001, 9, 0);
        run("-0",        32'h80000000, 1'b1, 32'h00000000, 3'b000, 1, 0);

        // Consumer stall: result and flags must hold, no new accept.
        run("stall",     32'h40490FDB, 1'b1, 32'h00000003, 3'b001, 8, 5);

        // Reset while the shifter is busy.
        @(negedge clk);
        in_data   = 32'h40490FDB;
        in_signed = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid-shift in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("after rst in_ready", in_ready, 1);
        check("after rst out_data", out_data, 0);
        repeat (10) @(negedge clk);
        check("no stale result", out_valid, 0);
        run("post-rst",  32'hC0200000, 1'b1, 32'hFFFFFFFE, 3'b001, 8, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
